// File: rtl/gcd_binary.sv
// Binary (Stein) GCD: one shift or subtract per cycle, start/ready handshake,
// single-cycle done pulse with the result held until the next done.
module gcd_binary #(
    parameter int unsigned WIDTH = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StShift, StCore, StFinish} state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic [KW-1:0]    r_k;

    logic w_a_zero;
    logic w_b_zero;
    logic w_both_even;

    assign w_a_zero    = (r_a == '0);
    assign w_b_zero    = (r_b == '0);
    // Zero operands never count as even here, so SHIFT cannot spin on them.
    assign w_both_even = !w_a_zero && !w_b_zero && !r_a[0] && !r_b[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (start) w_state_next = StShift;
            StShift:  if (!w_both_even) w_state_next = StCore;
            StCore:   if (w_a_zero || w_b_zero) w_state_next = StFinish;
            StFinish: w_state_next = start ? StShift : StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        ready = (r_state == StIdle) || (r_state == StFinish);
        done  = (r_state == StFinish);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_k      <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                StIdle, StFinish: begin
                    if (start) begin
                        r_a <= x;
                        r_b <= y;
                        r_k <= '0;
                    end
                end
                StShift: begin
                    if (w_both_even) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_k <= r_k + KW'(1);
                    end
                end
                StCore: begin
                    // Subtract only after the compare, so it never underflows.
                    if (w_a_zero) begin
                        r_result <= r_b << r_k;
                    end else if (w_b_zero) begin
                        r_result <= r_a << r_k;
                    end else if (!r_a[0]) begin
                        r_a <= r_a >> 1;
                    end else if (!r_b[0]) begin
                        r_b <= r_b >> 1;
                    end else if (r_a >= r_b) begin
                        r_a <= r_a - r_b;
                    end else begin
                        r_b <= r_b - r_a;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_gcd_binary.sv
// Directed, table-driven and random checks of gcd_binary at WIDTH=40 and WIDTH=8.
module tb_gcd_binary;

    logic        clk = 1'b0;
    logic        reset;
    logic        start40, start8;
    logic [39:0] x40, y40, result40;
    logic [7:0]  x8, y8, result8;
    logic        ready40, done40, ready8, done8;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    gcd_binary #(.WIDTH(40)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start40),
        .x      (x40),
        .y      (y40),
        .ready  (ready40),
        .done   (done40),
        .result (result40)
    );

    gcd_binary #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .start  (start8),
        .x      (x8),
        .y      (y8),
        .ready  (ready8),
        .done   (done8),
        .result (result8)
    );

    typedef struct {
        logic [39:0] xv;
        logic [39:0] yv;
        logic [39:0] exp;
        int          max_lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_lat(input string name, input int lat, input int max_lat);
        n_cmp++;
        if (lat < 1 || lat > max_lat) begin
            n_fail++;
            $display("FAIL %s: latency %0d, expected 1..%0d", name, lat, max_lat);
        end
    endtask

    function automatic logic [63:0] ref_gcd(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after a rising edge with the chosen DUT ready.
    task automatic job(input bit w8, input logic [63:0] xv, input logic [63:0] yv,
                       output logic [63:0] res, output int lat, output int busy_rdy);
        if (w8) begin
            start8 = 1'b1; x8 = xv[7:0]; y8 = yv[7:0];
        end else begin
            start40 = 1'b1; x40 = xv[39:0]; y40 = yv[39:0];
        end
        tick();
        start8 = 1'b0; start40 = 1'b0;
        x8 = '1; y8 = '1; x40 = '1; y40 = '1;
        lat = -1;
        res = '0;
        busy_rdy = 0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (w8 ? done8 : done40) begin
                lat = c;
                res = w8 ? {56'b0, result8} : {24'b0, result40};
                break;
            end
            if (w8 ? ready8 : ready40) busy_rdy++;
        end
    endtask

    vec_t        vecs[9];
    logic [63:0] res, rx, ry;
    int          lat, busy, pulses;

    initial begin
        vecs[0] = '{40'd0, 40'd35, 40'd35, 4};
        vecs[1] = '{40'd35, 40'd0, 40'd35, 4};
        vecs[2] = '{40'd0, 40'd0, 40'd0, 4};
        vecs[3] = '{40'h80_0000_0000, 40'h40_0000_0000, 40'h40_0000_0000, 164};
        vecs[4] = '{40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 164};
        vecs[5] = '{40'd17, 40'd5, 40'd1, 164};
        vecs[6] = '{40'd12, 40'd8, 40'd4, 164};
        vecs[7] = '{40'd1, 40'hFF_FFFF_FFFF, 40'd1, 164};
        vecs[8] = '{40'd1073741824, 40'd3221225472, 40'd1073741824, 164};

        // Reset with start asserted: start must be dropped.
        reset = 1'b1; start40 = 1'b1; start8 = 1'b0;
        x40 = 40'd48; y40 = 40'd18; x8 = '0; y8 = '0;
        tick(); tick();
        check("reset_ready", {63'b0, ready40}, 64'd1);
        check("reset_done", {63'b0, done40}, 64'd0);
        check("reset_result", {24'b0, result40}, 64'd0);
        reset = 1'b0; start40 = 1'b0;
        tick();
        check("start_dropped_ready", {63'b0, ready40}, 64'd1);

        // 48,18: nine cycles, one done pulse, result held afterwards.
        job(1'b0, 64'd48, 64'd18, res, lat, busy);
        check("g48_18_result", res, 64'd6);
        check("g48_18_latency", 64'(lat), 64'd9);
        check("g48_18_ready_low", 64'(busy), 64'd0);
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done40) pulses++;
        end
        check("g48_18_single_pulse", 64'(pulses), 64'd0);
        check("g48_18_result_hold", {24'b0, result40}, 64'd6);

        for (int i = 0; i < 9; i++) begin
            job(1'b0, {24'b0, vecs[i].xv}, {24'b0, vecs[i].yv}, res, lat, busy);
            check($sformatf("vec%0d_result", i), res, {24'b0, vecs[i].exp});
            check_lat($sformatf("vec%0d_latency", i), lat, vecs[i].max_lat);
        end

        // Start pulsed mid-operation with other operands is ignored.
        start40 = 1'b1; x40 = 40'd48; y40 = 40'd18;
        tick();
        start40 = 1'b0;
        tick(); tick(); tick();
        start40 = 1'b1; x40 = 40'd35; y40 = 40'd0;
        tick();
        start40 = 1'b0;
        lat = -1;
        for (int c = 5; c <= 40; c++) begin
            tick();
            if (done40) begin
                lat = c;
                break;
            end
        end
        check("midstart_latency", 64'(lat), 64'd9);
        check("midstart_result", {24'b0, result40}, 64'd6);

        // Start held through FINISH: back-to-back job with no idle cycle.
        tick();
        start40 = 1'b1; x40 = 40'd48; y40 = 40'd18;
        tick();
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done40) begin
                lat = c;
                break;
            end
        end
        check("b2b_first_latency", 64'(lat), 64'd9);
        x40 = 40'd0; y40 = 40'd35;
        tick();
        start40 = 1'b0;
        check("b2b_no_idle_ready", {63'b0, ready40}, 64'd0);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done40) begin
                lat = c;
                break;
            end
        end
        check("b2b_second_latency", 64'(lat), 64'd2);
        check("b2b_second_result", {24'b0, result40}, 64'd35);

        // Reset three cycles into a job aborts it silently.
        tick();
        start40 = 1'b1; x40 = 40'd48; y40 = 40'd18;
        tick();
        start40 = 1'b0;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done40) pulses++;
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        if (done40) pulses++;
        check("abort_no_done", 64'(pulses), 64'd0);
        check("abort_result", {24'b0, result40}, 64'd0);
        check("abort_ready", {63'b0, ready40}, 64'd1);
        job(1'b0, 64'd48, 64'd18, res, lat, busy);
        check("after_abort_result", res, 64'd6);
        check("after_abort_latency", 64'(lat), 64'd9);

        // Random regression at both widths against a Euclid reference.
        for (int i = 0; i < 40; i++) begin
            rx = {24'b0, 8'($urandom), $urandom} >> $urandom_range(0, 12);
            ry = {24'b0, 8'($urandom), $urandom} >> $urandom_range(0, 12);
            if (i % 4 == 0) begin
                rx = (rx << 5) & 64'hFF_FFFF_FFFF;
                ry = (ry << 3) & 64'hFF_FFFF_FFFF;
            end
            job(1'b0, rx, ry, res, lat, busy);
            check($sformatf("rand40_%0d_result", i), res, ref_gcd(rx, ry));
            check_lat($sformatf("rand40_%0d_latency", i), lat, 164);
        end
        for (int i = 0; i < 40; i++) begin
            rx = 64'($urandom_range(0, 255));
            ry = 64'($urandom_range(0, 255));
            job(1'b1, rx, ry, res, lat, busy);
            check($sformatf("rand8_%0d_result", i), res, ref_gcd(rx, ry));
            check_lat($sformatf("rand8_%0d_latency", i), lat, 36);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
